// File: rtl/dcache_stage_ctrl_if.sv
// dcache_stage_ctrl_if
//   Shared types for the memory-stage controller and the bus bundle that
//   connects it to the ALU, the data-memory port and write-back.
//
//   Package dcache_stage_pkg:
//     PC_WIDTH, REG_FILE_ADDR_W, REG_FILE_DATA_W  widths
//     dcache_size_t     Byte / Word access size
//     dcache_request_t  addr, size, is_store, data
//
//   Interface signals (directions as seen by the controller, modport master):
//     in : req_dcache_valid, req_dcache_info, req_dcache_pc, req_m_type_instr,
//          req_r_type_instr, req_dst_reg, mem_req_ready, mem_rsp_valid,
//          mem_rsp_data
//     out: stall_alu, mem_req_valid, mem_req_addr, mem_req_is_store,
//          mem_req_size, mem_req_data, req_wb_valid, req_wb_pc,
//          req_wb_rf_write, req_wb_dst_reg, req_wb_data, cache_data_bypass,
//          cache_data_bp_valid
//   Modport slave is the mirror view used by the surrounding pipeline/memory.

package dcache_stage_pkg;
  localparam int unsigned PC_WIDTH        = 32;
  localparam int unsigned REG_FILE_ADDR_W = 5;
  localparam int unsigned REG_FILE_DATA_W = 32;

  typedef enum logic {
    SIZE_BYTE = 1'b0,
    SIZE_WORD = 1'b1
  } dcache_size_t;

  typedef struct packed {
    logic [31:0]  addr;
    dcache_size_t size;
    logic         is_store;
    logic [31:0]  data;
  } dcache_request_t;
endpackage

interface dcache_stage_ctrl_if;
  // ALU request side
  logic                                        req_dcache_valid;
  dcache_stage_pkg::dcache_request_t           req_dcache_info;
  logic [dcache_stage_pkg::PC_WIDTH-1:0]        req_dcache_pc;
  logic                                        req_m_type_instr;
  logic                                        req_r_type_instr;
  logic [dcache_stage_pkg::REG_FILE_ADDR_W-1:0] req_dst_reg;
  logic                                        stall_alu;

  // Data-memory port
  logic                                        mem_req_valid;
  logic                                        mem_req_ready;
  logic [31:0]                                 mem_req_addr;
  logic                                        mem_req_is_store;
  dcache_stage_pkg::dcache_size_t              mem_req_size;
  logic [31:0]                                 mem_req_data;
  logic                                        mem_rsp_valid;
  logic [31:0]                                 mem_rsp_data;

  // Write-back side
  logic                                        req_wb_valid;
  logic [dcache_stage_pkg::PC_WIDTH-1:0]        req_wb_pc;
  logic                                        req_wb_rf_write;
  logic [dcache_stage_pkg::REG_FILE_ADDR_W-1:0] req_wb_dst_reg;
  logic [dcache_stage_pkg::REG_FILE_DATA_W-1:0] req_wb_data;

  // Cache-to-ALU bypass
  logic [31:0]                                 cache_data_bypass;
  logic                                        cache_data_bp_valid;

  modport master (
    input  req_dcache_valid, req_dcache_info, req_dcache_pc,
           req_m_type_instr, req_r_type_instr, req_dst_reg,
           mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output stall_alu, mem_req_valid, mem_req_addr, mem_req_is_store,
           mem_req_size, mem_req_data, req_wb_valid, req_wb_pc,
           req_wb_rf_write, req_wb_dst_reg, req_wb_data,
           cache_data_bypass, cache_data_bp_valid
  );

  modport slave (
    output req_dcache_valid, req_dcache_info, req_dcache_pc,
           req_m_type_instr, req_r_type_instr, req_dst_reg,
           mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  stall_alu, mem_req_valid, mem_req_addr, mem_req_is_store,
           mem_req_size, mem_req_data, req_wb_valid, req_wb_pc,
           req_wb_rf_write, req_wb_dst_reg, req_wb_data,
           cache_data_bypass, cache_data_bp_valid
  );
endinterface

// File: rtl/dcache_stage_ctrl.sv
// dcache_stage_ctrl
//   Memory-stage controller. Accepts one ALU request at a time while idle.
//   Non-memory requests (R-type, branch) retire to write-back one cycle after
//   acceptance. Loads/stores run a valid/ready request on the data-memory
//   port (loads then wait for a one-cycle response pulse); the ALU is stalled
//   whenever the controller is not idle.
//
//   Ports:
//     clock  rising-edge clock
//     reset  synchronous, active-high; returns to IDLE, clears all outputs
//     bus    dcache_stage_ctrl_if.master (request, memory, WB, bypass)
//
//   Build option:
//     DCACHE_BYPASS_EN  when defined, the write-back value is also presented
//                       on cache_data_bypass / cache_data_bp_valid; otherwise
//                       both bypass outputs are tied to 0.

module dcache_stage_ctrl
  import dcache_stage_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  dcache_stage_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEM_REQ = 2'd1,
    MEM_RSP = 2'd2
  } state_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0]        pc;
    dcache_request_t            info;
    logic [REG_FILE_ADDR_W-1:0] dst;
  } captured_t;

  state_t                      r_state;
  captured_t                   r_req;
  logic                        r_wb_valid;
  logic [PC_WIDTH-1:0]         r_wb_pc;
  logic                        r_wb_rf_write;
  logic [REG_FILE_ADDR_W-1:0]  r_wb_dst;
  logic [REG_FILE_DATA_W-1:0]  r_wb_data;

  logic [7:0]                  w_rsp_byte;
  logic [31:0]                 w_load_data;

  // Byte loads return the addressed lane of the aligned word, zero-extended.
  always_comb begin
    w_rsp_byte = '0;
    case (r_req.info.addr[1:0])
      2'd0: w_rsp_byte = bus.mem_rsp_data[7:0];
      2'd1: w_rsp_byte = bus.mem_rsp_data[15:8];
      2'd2: w_rsp_byte = bus.mem_rsp_data[23:16];
      default: w_rsp_byte = bus.mem_rsp_data[31:24];
    endcase
    w_load_data = (r_req.info.size == SIZE_WORD) ? bus.mem_rsp_data
                                                 : {24'h0, w_rsp_byte};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_req         <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_pc       <= '0;
      r_wb_rf_write <= 1'b0;
      r_wb_dst      <= '0;
      r_wb_data     <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_dcache_valid) begin
            r_req.pc   <= bus.req_dcache_pc;
            r_req.info <= bus.req_dcache_info;
            r_req.dst  <= bus.req_dst_reg;
            if (bus.req_m_type_instr) begin
              r_state <= MEM_REQ;
            end else begin
              // Retire straight from the inputs so WB lands one cycle later.
              r_wb_valid    <= 1'b1;
              r_wb_pc       <= bus.req_dcache_pc;
              r_wb_rf_write <= bus.req_r_type_instr;
              r_wb_dst      <= bus.req_dst_reg;
              r_wb_data     <= bus.req_dcache_info.data;
            end
          end
        end

        // A response pulse arriving here is deliberately not looked at.
        MEM_REQ: begin
          if (bus.mem_req_ready) begin
            if (r_req.info.is_store) begin
              r_state       <= IDLE;
              r_wb_valid    <= 1'b1;
              r_wb_pc       <= r_req.pc;
              r_wb_rf_write <= 1'b0;
              r_wb_dst      <= r_req.dst;
              r_wb_data     <= r_req.info.data;
            end else begin
              r_state <= MEM_RSP;
            end
          end
        end

        MEM_RSP: begin
          if (bus.mem_rsp_valid) begin
            r_state       <= IDLE;
            r_wb_valid    <= 1'b1;
            r_wb_pc       <= r_req.pc;
            r_wb_rf_write <= 1'b1;
            r_wb_dst      <= r_req.dst;
            r_wb_data     <= w_load_data;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.stall_alu        = (r_state != IDLE);
  assign bus.mem_req_valid    = (r_state == MEM_REQ);
  assign bus.mem_req_addr     = r_req.info.addr;
  assign bus.mem_req_is_store = r_req.info.is_store;
  assign bus.mem_req_size     = r_req.info.size;
  assign bus.mem_req_data     = r_req.info.data;

  assign bus.req_wb_valid     = r_wb_valid;
  assign bus.req_wb_pc        = r_wb_pc;
  assign bus.req_wb_rf_write  = r_wb_rf_write;
  assign bus.req_wb_dst_reg   = r_wb_dst;
  assign bus.req_wb_data      = r_wb_data;

`ifdef DCACHE_BYPASS_EN
  assign bus.cache_data_bp_valid = r_wb_valid & r_wb_rf_write;
  assign bus.cache_data_bypass   = r_wb_data;
`else
  assign bus.cache_data_bp_valid = 1'b0;
  assign bus.cache_data_bypass   = '0;
`endif

endmodule

// File: tb/tb_dcache_stage_ctrl.sv
// tb_dcache_stage_ctrl
//   Transaction-level bench for dcache_stage_ctrl. Each request is issued by
//   a task that knows the expected cycle-by-cycle outcome from the request
//   kind and the chosen memory delays; load data is predicted arithmetically
//   from the returned word and the address.

module tb_dcache_stage_ctrl;
  import dcache_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dcache_stage_ctrl_if dif ();

  dcache_stage_ctrl dut (
    .clock (clk),
    .reset (rst),
    .bus   (dif)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_idle_inputs();
    dif.req_dcache_valid = 1'b0;
    dif.req_m_type_instr = 1'b0;
    dif.req_r_type_instr = 1'b0;
    dif.mem_req_ready    = 1'b0;
    dif.mem_rsp_valid    = 1'b0;
  endtask

  task automatic check_bp(input logic exp_rf, input logic [31:0] exp_data);
`ifdef DCACHE_BYPASS_EN
    chk("bp_valid", 32'(dif.cache_data_bp_valid), 32'(exp_rf));
    if (exp_rf) chk("bp_data", dif.cache_data_bypass, exp_data);
`else
    chk("bp_valid", 32'(dif.cache_data_bp_valid), 32'(1'b0));
    chk("bp_data", dif.cache_data_bypass, 32'(exp_rf & 1'b0) | (exp_data & 32'h0));
`endif
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"},   32'(dif.stall_alu), 0);
    chk({tag, "_mvalid"},  32'(dif.mem_req_valid), 0);
    chk({tag, "_maddr"},   dif.mem_req_addr, 0);
    chk({tag, "_mstore"},  32'(dif.mem_req_is_store), 0);
    chk({tag, "_msize"},   32'(dif.mem_req_size), 0);
    chk({tag, "_mdata"},   dif.mem_req_data, 0);
    chk({tag, "_wbvalid"}, 32'(dif.req_wb_valid), 0);
    chk({tag, "_wbpc"},    dif.req_wb_pc, 0);
    chk({tag, "_wbrf"},    32'(dif.req_wb_rf_write), 0);
    chk({tag, "_wbdst"},   32'(dif.req_wb_dst_reg), 0);
    chk({tag, "_wbdata"},  dif.req_wb_data, 0);
    chk({tag, "_bpvalid"}, 32'(dif.cache_data_bp_valid), 0);
    chk({tag, "_bpdata"},  dif.cache_data_bypass, 0);
  endtask

  task automatic present(input logic m, input logic r, input logic [31:0] addr,
                         input dcache_size_t sz, input logic st,
                         input logic [31:0] data, input logic [31:0] pc,
                         input logic [4:0] dst);
    dif.req_dcache_valid = 1'b1;
    dif.req_m_type_instr = m;
    dif.req_r_type_instr = r;
    dif.req_dcache_info  = '{addr: addr, size: sz, is_store: st, data: data};
    dif.req_dcache_pc    = pc;
    dif.req_dst_reg      = dst;
  endtask

  // Non-memory request: retires on the very next cycle. Leaves the request
  // inputs asserted so a caller can chain another one back-to-back.
  task automatic do_nonmem(input logic r, input logic [31:0] pc,
                           input logic [4:0] dst, input logic [31:0] data);
    chk("nm_pre_stall", 32'(dif.stall_alu), 0);
    present(1'b0, r, $urandom, dcache_size_t'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), data, pc, dst);
    dif.mem_rsp_valid = 1'($urandom_range(0, 1));
    dif.mem_req_ready = 1'($urandom_range(0, 1));
    tick();
    chk("nm_wbvalid", 32'(dif.req_wb_valid), 1);
    chk("nm_wbrf",    32'(dif.req_wb_rf_write), 32'(r));
    chk("nm_wbdst",   32'(dif.req_wb_dst_reg), 32'(dst));
    chk("nm_wbdata",  dif.req_wb_data, data);
    chk("nm_wbpc",    dif.req_wb_pc, pc);
    chk("nm_stall",   32'(dif.stall_alu), 0);
    chk("nm_mvalid",  32'(dif.mem_req_valid), 0);
    check_bp(r, data);
  endtask

  // Memory request with rdy_d cycles of ready held low, then (loads only)
  // rsp_d idle cycles before the response pulse.
  task automatic do_mem(input logic st, input dcache_size_t sz,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] pc, input logic [4:0] dst,
                        input int unsigned rdy_d, input int unsigned rsp_d,
                        input logic [31:0] word);
    logic [31:0] exp;
    chk("m_pre_stall", 32'(dif.stall_alu), 0);
    present(1'b1, 1'b0, addr, sz, st, data, pc, dst);
    tick();
    set_idle_inputs();
    for (int unsigned i = 0; i <= rdy_d; i++) begin
      chk("m_req_stall",  32'(dif.stall_alu), 1);
      chk("m_req_valid",  32'(dif.mem_req_valid), 1);
      chk("m_req_addr",   dif.mem_req_addr, addr);
      chk("m_req_store",  32'(dif.mem_req_is_store), 32'(st));
      chk("m_req_size",   32'(dif.mem_req_size), 32'(sz));
      if (st) chk("m_req_data", dif.mem_req_data, data);
      chk("m_req_nowb",   32'(dif.req_wb_valid), 0);
      dif.mem_req_ready = (i == rdy_d);
      dif.mem_rsp_valid = 1'($urandom_range(0, 1));
      dif.mem_rsp_data  = $urandom;
      tick();
    end
    set_idle_inputs();
    if (st) begin
      chk("st_wbvalid", 32'(dif.req_wb_valid), 1);
      chk("st_wbrf",    32'(dif.req_wb_rf_write), 0);
      chk("st_wbpc",    dif.req_wb_pc, pc);
      chk("st_wbdst",   32'(dif.req_wb_dst_reg), 32'(dst));
      chk("st_stall",   32'(dif.stall_alu), 0);
      chk("st_mvalid",  32'(dif.mem_req_valid), 0);
      check_bp(1'b0, 32'h0);
      return;
    end
    for (int unsigned j = 0; j <= rsp_d; j++) begin
      chk("ld_wait_stall",  32'(dif.stall_alu), 1);
      chk("ld_wait_mvalid", 32'(dif.mem_req_valid), 0);
      chk("ld_wait_nowb",   32'(dif.req_wb_valid), 0);
      dif.mem_rsp_valid = (j == rsp_d);
      dif.mem_rsp_data  = (j == rsp_d) ? word : $urandom;
      dif.mem_req_ready = 1'($urandom_range(0, 1));
      tick();
    end
    set_idle_inputs();
    exp = (sz == SIZE_WORD) ? word : ((word >> (8 * addr[1:0])) & 32'hFF);
    chk("ld_wbvalid", 32'(dif.req_wb_valid), 1);
    chk("ld_wbrf",    32'(dif.req_wb_rf_write), 1);
    chk("ld_wbdata",  dif.req_wb_data, exp);
    chk("ld_wbpc",    dif.req_wb_pc, pc);
    chk("ld_wbdst",   32'(dif.req_wb_dst_reg), 32'(dst));
    chk("ld_stall",   32'(dif.stall_alu), 0);
    check_bp(1'b1, exp);
  endtask

  task automatic idle_cycle();
    set_idle_inputs();
    dif.mem_rsp_valid = 1'($urandom_range(0, 1));
    dif.mem_req_ready = 1'($urandom_range(0, 1));
    dif.mem_rsp_data  = $urandom;
    tick();
    chk("idle_nowb",   32'(dif.req_wb_valid), 0);
    chk("idle_stall",  32'(dif.stall_alu), 0);
    chk("idle_mvalid", 32'(dif.mem_req_valid), 0);
    check_bp(1'b0, 32'h0);
    set_idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=0x%08h exp=0x%08h", n_checks, 0);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    dcache_size_t sz;
    set_idle_inputs();
    dif.req_dcache_info = '0;
    dif.req_dcache_pc   = '0;
    dif.req_dst_reg     = '0;
    dif.mem_rsp_data    = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_all_zero("rst");

    // R-type dst=5, data=7
    do_nonmem(1'b1, 32'h0000_1000, 5'd5, 32'h0000_0007);
    set_idle_inputs();
    // LDW 0x100, ready low for 3 cycles
    do_mem(1'b0, SIZE_WORD, 32'h100, 32'h0, 32'h1004, 5'd6, 3, 0, 32'hDEAD_BEEF);
    // LDB 0x103
    do_mem(1'b0, SIZE_BYTE, 32'h103, 32'h0, 32'h1008, 5'd7, 0, 2, 32'hAABB_CCDD);
    // STB 0x40, ready at once
    do_mem(1'b1, SIZE_BYTE, 32'h40, 32'h12, 32'h100C, 5'd8, 0, 0, 32'h0);
    // Branch then R-type back-to-back
    do_nonmem(1'b0, 32'h1010, 5'd9, 32'h55);
    do_nonmem(1'b1, 32'h1014, 5'd10, 32'h66);
    set_idle_inputs();
    idle_cycle();

    // Reset while waiting for a load response; late response must be dropped
    present(1'b1, 1'b0, 32'h200, SIZE_WORD, 1'b0, 32'h0, 32'h1018, 5'd11);
    tick();
    set_idle_inputs();
    dif.mem_req_ready = 1'b1;
    tick();
    set_idle_inputs();
    chk("rsp_wait_stall", 32'(dif.stall_alu), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midrst");
    dif.mem_rsp_valid = 1'b1;
    dif.mem_rsp_data  = 32'h1234_5678;
    tick();
    set_idle_inputs();
    check_all_zero("drop");

    // Randomized traffic
    for (int unsigned t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        0: begin do_nonmem(1'b0, $urandom, 5'($urandom), $urandom); set_idle_inputs(); end
        1: begin do_nonmem(1'b1, $urandom, 5'($urandom), $urandom); set_idle_inputs(); end
        default: begin
          sz = dcache_size_t'($urandom_range(0, 1));
          a = $urandom;
          if (sz == SIZE_WORD) a[1:0] = 2'b00;
          do_mem(1'($urandom_range(0, 1)), sz, a, $urandom, $urandom, 5'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end
      endcase
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dcache_stage_ctrl.md
# dcache_stage_ctrl

Memory-stage controller that receives the ALU's D$ request stream and carries each instruction to write-back. R-type and branch requests pass through with one cycle of latency. Loads and stores run a request/response transaction on the data-memory port, and the block stalls the ALU until that transaction completes. It also drives the cache-to-ALU bypass (`cache_data_bypass`, `cache_data_bp_valid`).

## Interface
- No parameters; widths come from `soc.vh` (`REG_FILE_DATA_RANGE` is 32 bits, `REG_FILE_ADDR_RANGE`, `PC_WIDTH`).
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_dcache_valid`  in  1  request from ALU valid.
- `req_dcache_info`  in  dcache_request_t  addr, size (Byte/Word), is_store, data.
- `req_dcache_pc`  in  PC_WIDTH  PC of the request.
- `req_m_type_instr`  in  1  request accesses memory.
- `req_r_type_instr`  in  1  request writes the RF with `info.data`.
- `req_dst_reg`  in  REG_FILE_ADDR_RANGE  destination register.
- `stall_alu`  out  1  ALU must hold its outputs.
- `mem_req_valid`  out  1  memory request valid.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_req_addr`  out  32  byte address.
- `mem_req_is_store`  out  1  store request.
- `mem_req_size`  out  size type  Byte/Word.
- `mem_req_data`  out  32  store data.
- `mem_rsp_valid`  in  1  load data returned (one-cycle pulse).
- `mem_rsp_data`  in  32  aligned word containing the addressed byte(s).
- `req_wb_valid`  out  1  instruction completes to WB (one-cycle pulse).
- `req_wb_pc`  out  PC_WIDTH  PC of the retiring instruction.
- `req_wb_rf_write`  out  1  WB must write the RF.
- `req_wb_dst_reg`  out  REG_FILE_ADDR_RANGE  RF write address.
- `req_wb_data`  out  32  RF write data.
- `cache_data_bypass`  out  32  bypass data.
- `cache_data_bp_valid`  out  1  bypass data valid.

## Operation
- FSM states: IDLE, MEM_REQ, MEM_RSP. Reset puts the FSM in IDLE.
- Reset values: every output is 0.
- A request is accepted only in IDLE with `req_dcache_valid` high. The accepted request's pc, info, dst_reg and type bits are captured in an internal register.
- **Non-memory request** (`req_m_type_instr` = 0):
  - FSM stays in IDLE.
  - The next cycle pulses `req_wb_valid` with `req_wb_rf_write` = `req_r_type_instr` and `req_wb_data` = `info.data`.
  - Branch requests (neither type bit set) retire with `req_wb_rf_write` = 0.
- **Memory request**: the FSM moves to MEM_REQ.
  - `mem_req_*` are driven from the captured request.
  - `mem_req_valid` is held with stable fields until the cycle `mem_req_ready` is high.
- **Store**: on the MEM_REQ handshake the FSM returns to IDLE. The next cycle pulses `req_wb_valid` with `req_wb_rf_write` = 0.
- **Load**: on the MEM_REQ handshake the FSM moves to MEM_RSP.
  - When `mem_rsp_valid` is high, the FSM returns to IDLE.
  - The next cycle pulses `req_wb_valid` with `req_wb_rf_write` = 1 and the extracted data.
- **Load data extraction**:
  - Word: `mem_rsp_data` as-is.
  - Byte: byte `addr[1:0]` of `mem_rsp_data`, i.e. bits [8k+7:8k] with k = `addr[1:0]`, zero-extended to 32 bits.
- `stall_alu` = (state != IDLE), driven combinationally from the state register.
- `mem_rsp_valid` in IDLE or MEM_REQ is ignored, with no state or output change.
- `mem_req_ready` outside MEM_REQ is ignored.

## Timing
- Request accepted in cycle N:
  - R-type or branch: WB pulse in N+1.
  - Memory request: `mem_req_valid` high from N+1; `stall_alu` high from N+1.
- Store, handshake in cycle H: WB pulse in H+1; `stall_alu` low in H+1.
- Load, response in cycle R: WB pulse in R+1; `stall_alu` low in R+1.
- Minimum load latency: accept N, ready in N+1, response in N+2, WB in N+3.
- Back-to-back R-type requests sustain one WB pulse per cycle.
- `mem_req_ready` and `mem_rsp_valid` in the same cycle while in MEM_REQ: only the request handshake counts, and the response is ignored.
- Reset asserted mid-transaction: the FSM goes to IDLE and all outputs are 0 in the next cycle. Any later response is dropped.

## Configuration
- `DCACHE_BYPASS_EN` defined:
  - `cache_data_bp_valid` = `req_wb_valid` & `req_wb_rf_write`.
  - `cache_data_bypass` = `req_wb_data`, in the same cycle as the WB pulse.
- Undefined: `cache_data_bp_valid` and `cache_data_bypass` are tied to 0, and the ALU relies on RF forwarding only.

## Test plan
- R-type: dst=5, data=0x0000_0007 in cycle 1 -> cycle 2 shows `req_wb_valid`=1, `rf_write`=1, `dst_reg`=5, `data`=0x7, `stall_alu`=0, and bypass valid with 0x7 when `DCACHE_BYPASS_EN` is defined.
- LDW addr=0x100, `mem_req_ready` held low for 3 cycles, response 0xDEAD_BEEF -> `mem_req_valid` held with addr 0x100 for 4 cycles; WB data = 0xDEADBEEF; `stall_alu` high from accept+1 until the WB cycle.
- LDB addr=0x103, response 0xAABB_CCDD -> WB data = 0x0000_00AA.
- STB addr=0x40, data=0x12, ready in the first cycle -> `mem_req_is_store`=1, size=Byte; WB pulse with `rf_write`=0 two cycles after accept; `mem_rsp_valid` pulses during MEM_REQ are ignored.
- Reset asserted while in MEM_RSP, then `mem_rsp_valid` arrives -> no WB pulse, all outputs 0, FSM in IDLE.
- Branch request (both type bits 0) followed immediately by R-type -> two consecutive WB pulses, the first with `rf_write`=0.
